// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// the access-size decoder used at request acceptance.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic       legal;
    logic       is_signed;
    logic [3:0] size;
  } lsu_dec_t;

  // Unsigned variants only exist for loads; the doubleword forms need XLEN=64.
  function automatic lsu_dec_t decode_size(input logic [2:0] funct3,
                                           input logic       write,
                                           input int         xlen);
    lsu_dec_t d;
    d.legal     = 1'b0;
    d.is_signed = 1'b0;
    d.size      = 4'd0;
    case (funct3)
      F3_B:  begin d.legal = 1'b1;                    d.is_signed = 1'b1; d.size = 4'd1; end
      F3_H:  begin d.legal = 1'b1;                    d.is_signed = 1'b1; d.size = 4'd2; end
      F3_W:  begin d.legal = 1'b1;                    d.is_signed = 1'b1; d.size = 4'd4; end
      F3_D:  begin d.legal = (xlen == 64);            d.is_signed = 1'b1; d.size = 4'd8; end
      F3_BU: begin d.legal = !write;                  d.is_signed = 1'b0; d.size = 4'd1; end
      F3_HU: begin d.legal = !write;                  d.is_signed = 1'b0; d.size = 4'd2; end
      F3_WU: begin d.legal = !write && (xlen == 64);  d.is_signed = 1'b0; d.size = 4'd4; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/lsu_mem_if_if.sv
// Core-side request/response channel and memory-side beat channel of the LSU.
//
// Handshakes: a request transfers on the rising clk edge where req_valid && req_ready;
// resp_valid is a one-cycle pulse with no back-pressure, resp_err/resp_rdata qualified by it;
// a bus beat completes on the edge where mem_req && mem_ack, and all mem_* outputs
// hold steady until then; mem_ack without mem_req is ignored.
interface lsu_req_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic              resp_err;
  logic [XLEN-1:0]   resp_rdata;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

interface lsu_bus_if #(parameter int XLEN = 32, parameter int ADDR_W = 32);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables and write data for both beats, and the
// merge/extension of the two read words into the load result.
module lsu_align #(
  parameter int XLEN = 32
) (
  input  logic [3:0]                 size,
  input  logic [$clog2(XLEN/8)-1:0]  off,
  input  logic                       is_signed,
  input  logic [XLEN-1:0]            wdata,
  input  logic [XLEN-1:0]            rd0,
  input  logic [XLEN-1:0]            rd1,
  output logic [XLEN/8-1:0]          be0,
  output logic [XLEN/8-1:0]          be1,
  output logic [XLEN-1:0]            wd0,
  output logic [XLEN-1:0]            wd1,
  output logic [XLEN-1:0]            load_data
);

  localparam int BYTES = XLEN / 8;

  logic [2*BYTES-1:0] be_full;
  logic [2*XLEN-1:0]  wd_full;
  logic [2*XLEN-1:0]  rd_pair;
  logic [XLEN-1:0]    merged;
  logic               sign_bit;

  // Shifting across a double-width window yields beat0 in the low half and the
  // spill-over for beat1 in the high half with no special cases.
  always_comb begin
    be_full = ((2*BYTES)'(1) << size) - (2*BYTES)'(1);
    be_full = be_full << off;
    wd_full = {{XLEN{1'b0}}, wdata} << {off, 3'b000};
    rd_pair = {rd1, rd0} >> {off, 3'b000};
    merged  = rd_pair[XLEN-1:0];

    be0 = be_full[BYTES-1:0];
    be1 = be_full[2*BYTES-1:BYTES];
    wd0 = wd_full[XLEN-1:0];
    wd1 = wd_full[2*XLEN-1:XLEN];

    sign_bit = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (i == int'(size) - 1) sign_bit = merged[8*i+7 +: 1];
    end

    load_data = '0;
    for (int i = 0; i < BYTES; i++) begin
      load_data[8*i +: 8] = (i < int'(size)) ? merged[8*i +: 8] : {8{is_signed & sign_bit}};
    end
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit between the core datapath and the data bus: request capture,
// beat sequencing FSM and response generation.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int ADDR_W           = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  lsu_req_if.slave   req,
  lsu_bus_if.master  bus,
  output lsu_state_e state_dbg
);

  localparam int BYTES = XLEN / 8;
  localparam int OFF_W = $clog2(BYTES);

  lsu_state_e        state, state_nxt;
  logic              write_q, signed_q, cross_q, err_q;
  logic [3:0]        size_q;
  logic [OFF_W-1:0]  off_q;
  logic [ADDR_W-1:0] word_q;
  logic [XLEN-1:0]   wdata_q, rd0_q, rd1_q;

  lsu_dec_t          dec;
  logic [OFF_W-1:0]  req_off;
  logic              req_cross, req_bad, accept;

  logic [BYTES-1:0]  be0, be1;
  logic [XLEN-1:0]   wd0, wd1, load_data;

  always_comb begin
    dec       = decode_size(req.req_funct3, req.req_write, XLEN);
    req_off   = req.req_addr[OFF_W-1:0];
    req_cross = (int'(req_off) + int'(dec.size)) > BYTES;
    req_bad   = !dec.legal || (req_cross && !ALLOW_MISALIGNED);
    accept    = (state == ST_IDLE) && req.req_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req.req_valid) state_nxt = req_bad ? ST_RESP : ST_BEAT0;
      ST_BEAT0: if (bus.mem_ack)   state_nxt = cross_q ? ST_BEAT1 : ST_RESP;
      ST_BEAT1: if (bus.mem_ack)   state_nxt = ST_RESP;
      ST_RESP:                     state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Everything the beats and the response need is frozen here, so the request
  // inputs are free to change right after acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q  <= 1'b0;
      signed_q <= 1'b0;
      cross_q  <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      off_q    <= '0;
      word_q   <= '0;
      wdata_q  <= '0;
      rd0_q    <= '0;
      rd1_q    <= '0;
    end else begin
      if (accept) begin
        write_q  <= req.req_write;
        signed_q <= dec.is_signed;
        cross_q  <= req_cross;
        err_q    <= req_bad;
        size_q   <= dec.size;
        off_q    <= req_off;
        word_q   <= {req.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_q  <= req.req_wdata;
      end
      if (state == ST_BEAT0 && bus.mem_ack) rd0_q <= bus.mem_rdata;
      if (state == ST_BEAT1 && bus.mem_ack) rd1_q <= bus.mem_rdata;
    end
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .size      (size_q),
    .off       (off_q),
    .is_signed (signed_q),
    .wdata     (wdata_q),
    .rd0       (rd0_q),
    .rd1       (rd1_q),
    .be0       (be0),
    .be1       (be1),
    .wd0       (wd0),
    .wd1       (wd1),
    .load_data (load_data)
  );

  // Outputs decode only the state and capture flops, so they are stable for a
  // whole beat and fall with the asynchronous reset.
  always_comb begin
    req.req_ready  = (state == ST_IDLE);
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_be     = '0;
    bus.mem_wdata  = '0;
    req.resp_valid = 1'b0;
    req.resp_err   = 1'b0;
    req.resp_rdata = '0;
    case (state)
      ST_BEAT0: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = write_q;
        bus.mem_addr  = word_q;
        bus.mem_be    = be0;
        bus.mem_wdata = wd0;
      end
      ST_BEAT1: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = write_q;
        bus.mem_addr  = word_q + ADDR_W'(BYTES);
        bus.mem_be    = be1;
        bus.mem_wdata = wd1;
      end
      ST_RESP: begin
        req.resp_valid = 1'b1;
        req.resp_err   = err_q;
        req.resp_rdata = (err_q || write_q) ? '0 : load_data;
      end
      default: ;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: one instance allowing split accesses, one rejecting them.
module tb_lsu_mem_if;
  import lsu_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lsu_req_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) rq   ();
  lsu_bus_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bs   ();
  lsu_req_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) rq_n ();
  lsu_bus_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bs_n ();
  lsu_state_e st_a, st_n;

  lsu_mem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req(rq.slave), .bus(bs.master), .state_dbg(st_a)
  );
  lsu_mem_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .reset(reset), .req(rq_n.slave), .bus(bs_n.master), .state_dbg(st_n)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN:0] exp_q[$];
  logic [XLEN:0] mon_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_resp(input logic err, input logic [XLEN-1:0] rdata);
    exp_q.push_back({err, rdata});
  endtask

  always @(negedge clk) begin
    if (reset && rq.resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_err", {63'd0, rq.resp_err}, {63'd0, mon_e[XLEN]});
        chk("resp_rdata", {32'd0, rq.resp_rdata}, {32'd0, mon_e[XLEN-1:0]});
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_a(input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
    chk("ready_before_req", {63'd0, rq.req_ready}, 64'd1);
    rq.req_valid  = 1'b1;
    rq.req_write  = wr;
    rq.req_funct3 = f3;
    rq.req_addr   = addr;
    rq.req_wdata  = wd;
    @(negedge clk);
    rq.req_valid  = 1'b0;
    rq.req_write  = 1'($urandom_range(0, 1));
    rq.req_funct3 = 3'($urandom_range(0, 7));
    rq.req_addr   = $urandom;
    rq.req_wdata  = $urandom;
  endtask

  task automatic do_beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                         input logic ewe, input logic [31:0] ewd,
                         input int wait_n, input logic [31:0] rd);
    for (int i = 0; i <= wait_n; i++) begin
      chk({tag, "_req"},   {63'd0, bs.mem_req}, 64'd1);
      chk({tag, "_addr"},  {32'd0, bs.mem_addr}, {32'd0, ea});
      chk({tag, "_be"},    {60'd0, bs.mem_be}, {60'd0, ebe});
      chk({tag, "_we"},    {63'd0, bs.mem_we}, {63'd0, ewe});
      chk({tag, "_wdata"}, {32'd0, bs.mem_wdata}, {32'd0, ewd});
      if (i == wait_n) begin
        bs.mem_ack   = 1'b1;
        bs.mem_rdata = rd;
      end
      @(negedge clk);
    end
    bs.mem_ack   = 1'b0;
    bs.mem_rdata = $urandom;
  endtask

  task automatic end_resp(input string tag);
    chk({tag, "_resp_valid"}, {63'd0, rq.resp_valid}, 64'd1);
    chk({tag, "_req_gap"},    {63'd0, bs.mem_req}, 64'd0);
    chk({tag, "_ready_busy"}, {63'd0, rq.req_ready}, 64'd0);
    @(negedge clk);
    chk({tag, "_resp_drop"},  {63'd0, rq.resp_valid}, 64'd0);
    chk({tag, "_ready_back"}, {63'd0, rq.req_ready}, 64'd1);
    chk({tag, "_rdata_idle"}, {32'd0, rq.resp_rdata}, 64'd0);
    chk({tag, "_err_idle"},   {63'd0, rq.resp_err}, 64'd0);
  endtask

  task automatic send_err_n(input string tag, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr);
    chk({tag, "_ready"}, {63'd0, rq_n.req_ready}, 64'd1);
    rq_n.req_valid  = 1'b1;
    rq_n.req_write  = wr;
    rq_n.req_funct3 = f3;
    rq_n.req_addr   = addr;
    rq_n.req_wdata  = $urandom;
    @(negedge clk);
    rq_n.req_valid  = 1'b0;
    chk({tag, "_mem_req"},    {63'd0, bs_n.mem_req}, 64'd0);
    chk({tag, "_resp_valid"}, {63'd0, rq_n.resp_valid}, 64'd1);
    chk({tag, "_resp_err"},   {63'd0, rq_n.resp_err}, 64'd1);
    chk({tag, "_resp_rdata"}, {32'd0, rq_n.resp_rdata}, 64'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, {63'd0, rq_n.req_ready}, 64'd1);
    chk({tag, "_resp_drop"},  {63'd0, rq_n.resp_valid}, 64'd0);
    chk({tag, "_mem_req2"},   {63'd0, bs_n.mem_req}, 64'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, checks=%0d", n_checks);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    rq.req_valid = 1'b0; rq.req_write = 1'b0; rq.req_funct3 = '0; rq.req_addr = '0; rq.req_wdata = '0;
    rq_n.req_valid = 1'b0; rq_n.req_write = 1'b0; rq_n.req_funct3 = '0; rq_n.req_addr = '0; rq_n.req_wdata = '0;
    bs.mem_ack = 1'b0; bs.mem_rdata = '0;
    bs_n.mem_ack = 1'b0; bs_n.mem_rdata = '0;

    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {63'd0, rq.req_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, rq.resp_valid}, 64'd0);
    chk("rst_resp_err",   {63'd0, rq.resp_err}, 64'd0);
    chk("rst_resp_rdata", {32'd0, rq.resp_rdata}, 64'd0);
    chk("rst_mem_req",    {63'd0, bs.mem_req}, 64'd0);
    chk("rst_mem_we",     {63'd0, bs.mem_we}, 64'd0);
    chk("rst_mem_addr",   {32'd0, bs.mem_addr}, 64'd0);
    chk("rst_mem_be",     {60'd0, bs.mem_be}, 64'd0);
    chk("rst_mem_wdata",  {32'd0, bs.mem_wdata}, 64'd0);
    chk("rst_state",      {62'd0, st_a}, {62'd0, ST_IDLE});
    reset = 1'b1;
    @(negedge clk);

    // stray ack while idle
    bs.mem_ack = 1'b1; bs.mem_rdata = $urandom;
    @(negedge clk);
    bs.mem_ack = 1'b0;
    chk("idle_ack_mem_req", {63'd0, bs.mem_req}, 64'd0);
    chk("idle_ack_ready",   {63'd0, rq.req_ready}, 64'd1);
    chk("idle_ack_resp",    {63'd0, rq.resp_valid}, 64'd0);

    // SW aligned, ack two cycles after mem_req
    expect_resp(1'b0, 32'h0);
    send_a(1'b1, F3_W, 32'h0000_0100, 32'hDEAD_BEEF);
    do_beat("sw", 32'h0000_0100, 4'b1111, 1'b1, 32'hDEAD_BEEF, 2, $urandom);
    end_resp("sw");

    // LB / LBU at the top byte lane
    expect_resp(1'b0, 32'hFFFF_FF80);
    send_a(1'b0, F3_B, 32'h0000_0103, 32'h0);
    do_beat("lb", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0, 32'h8012_3456);
    end_resp("lb");

    expect_resp(1'b0, 32'h0000_0080);
    send_a(1'b0, F3_BU, 32'h0000_0103, 32'h0);
    do_beat("lbu", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 0, 32'h8012_3456);
    end_resp("lbu");

    // LH / LHU in the upper half-word
    expect_resp(1'b0, 32'hFFFF_8001);
    send_a(1'b0, F3_H, 32'h0000_0102, 32'h0);
    do_beat("lh", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 1, 32'h8001_0000);
    end_resp("lh");

    expect_resp(1'b0, 32'h0000_F00D);
    send_a(1'b0, F3_HU, 32'h0000_0102, 32'h0);
    do_beat("lhu", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 0, 32'hF00D_1234);
    end_resp("lhu");

    // LW crossing a word boundary, split into two beats
    expect_resp(1'b0, 32'h6655_4433);
    send_a(1'b0, F3_W, 32'h0000_0102, 32'h0);
    do_beat("lw_b0", 32'h0000_0100, 4'b1100, 1'b0, 32'h0, 1, 32'h4433_2211);
    do_beat("lw_b1", 32'h0000_0104, 4'b0011, 1'b0, 32'h0, 0, 32'h8877_6655);
    end_resp("lw_split");

    // SH at the last byte of the address space wraps to address 0
    expect_resp(1'b0, 32'h0);
    send_a(1'b1, F3_H, 32'hFFFF_FFFF, 32'h0000_AABB);
    do_beat("sh_b0", 32'hFFFF_FFFC, 4'b1000, 1'b1, 32'hBB00_0000, 1, $urandom);
    do_beat("sh_b1", 32'h0000_0000, 4'b0001, 1'b1, 32'h0000_00AA, 0, $urandom);
    end_resp("sh_wrap");

    // illegal codes on a 32-bit unit: SD and funct3=111
    expect_resp(1'b1, 32'h0);
    send_a(1'b1, F3_D, 32'h0000_0010, $urandom);
    end_resp("sd_err");
    expect_resp(1'b1, 32'h0);
    send_a(1'b0, 3'b111, 32'h0000_0010, 32'h0);
    end_resp("f3_111_err");

    // rejection instance
    send_err_n("na_sh_mis", 1'b1, F3_H, 32'h0000_0003);
    send_err_n("na_ld",     1'b0, F3_D, 32'h0000_0020);

    // reset while a beat is outstanding
    send_a(1'b0, F3_W, 32'h0000_0200, 32'h0);
    chk("abort_mem_req_pre", {63'd0, bs.mem_req}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_req_async", {63'd0, bs.mem_req}, 64'd0);
    chk("abort_mem_addr",      {32'd0, bs.mem_addr}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready",   {63'd0, rq.req_ready}, 64'd1);
    chk("abort_mem_req", {63'd0, bs.mem_req}, 64'd0);
    repeat (4) @(negedge clk);
    chk("abort_no_resp", {63'd0, rq.resp_valid}, 64'd0);

    // normal operation after the abort
    expect_resp(1'b0, 32'h1234_5678);
    send_a(1'b0, F3_W, 32'h0000_0040, 32'h0);
    do_beat("lw_post", 32'h0000_0040, 4'b1111, 1'b0, 32'h0, 0, 32'h1234_5678);
    end_resp("lw_post");

    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
